ehl_rv_pack: RTL and testbench
==============================

EHL_RV_PACK -- requirements
Module: ehl_rv_pack

Interface
REQ-001 Parameter WIDTH, default 8: input beat width in bits.
REQ-002 Parameter RATIO, default 4: input beats per output word; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 data_in  input  WIDTH  upstream beat data.
REQ-008 in_last  input  1  beat closes current word early; sampled only on accepted beats.
REQ-009 out_valid  output  1  packed word valid (registered).
REQ-010 out_ready  input  1  downstream accepts word.
REQ-011 data_out  output  WIDTH*RATIO  packed word (registered).
REQ-012 out_keep  output  RATIO  lane-valid mask, bit i = lane i holds data (registered).
REQ-013 out_last  output  1  word was closed by in_last (registered).

Function
REQ-014 Transfer rules: input beat accepted when in_valid & in_ready; output word consumed when out_valid & out_ready.
REQ-015 in_ready = !out_valid | out_ready; combinational; no dependence on in_valid.
REQ-016 Lane index counter cnt, range 0..RATIO-1, selects the destination lane of the next accepted beat.
REQ-017 Lane i occupies data_out[i*WIDTH +: WIDTH]; first beat of a word -> lane 0 (little-endian lane order).
REQ-018 Accepted beat: write data_in into lane cnt, set out_keep[cnt].
REQ-019 Word completes on the accepted beat where cnt = RATIO-1 or in_last = 1; next cycle out_valid = 1, out_last = in_last of that beat, cnt = 0.
REQ-020 Accepted beat that does not complete a word: cnt increments by 1; out_valid stays 0.
REQ-021 While out_valid = 1 and out_ready = 0: data_out, out_keep, out_last, cnt held; in_ready = 0; no beat accepted.
REQ-022 Word consumed without a same-cycle accepted beat: next cycle out_valid = 0, data_out = 0, out_keep = 0, out_last = 0.
REQ-023 Word consumed with a same-cycle accepted beat: old word dropped; beat starts new word in lane 0; all other lanes and keep bits cleared; no bubble.
REQ-024 Full throughput: with in_valid and out_ready held high, one word per RATIO cycles, no stalls.
REQ-025 Unfilled lanes of a short word read as zero; out_keep is contiguous from bit 0.
REQ-026 Beat with in_last = 1 at cnt = RATIO-1: single completion, out_keep all ones, out_last = 1.
REQ-027 No state change when in_valid = 0, except output clearing per REQ-022.
REQ-028 Latency: accepted completing beat -> out_valid high on the next rising edge.

Reset
REQ-029 reset high asynchronously forces out_valid = 0, data_out = 0, out_keep = 0, out_last = 0, cnt = 0.
REQ-030 Reset mid-word discards the partial word; first beat after reset release lands in lane 0.
REQ-031 in_ready = 1 throughout reset and after release (follows REQ-015 with out_valid = 0).

Verification (WIDTH=8, RATIO=4)
REQ-032 Beats 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one cycle after 4th beat: data_out=0x44332211, out_keep=4'b1111, out_last=0.
REQ-033 Beats 0xAA,0xBB with in_last on 0xBB -> data_out=0x0000BBAA, out_keep=4'b0011, out_last=1; next beat lands in lane 0.
REQ-034 Completed word, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, outputs stable 5 cycles; on release consumption and lane-0 acceptance in the same cycle.
REQ-035 Continuous stream 0x01..0x0C, in_valid=1, out_ready=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09 at 4-cycle spacing, no stalls.
REQ-036 Reset asserted after 2 beats (0x55,0x66), then beats 0x77..0x7A -> data_out=0x7A797877, out_keep=4'b1111; 0x55/0x66 never appear.
REQ-037 Single beat 0xF0 with in_last at cnt=0 -> data_out=0x000000F0, out_keep=4'b0001, out_last=1.

Source files
------------

// File: rtl/ehl_rv_pack.sv
// Ready/valid beat packer: gathers RATIO beats of WIDTH bits into one word, lane 0 first.
// A beat flagged in_last closes the word early; unfilled lanes stay zero.
module ehl_rv_pack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] data_out,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CntMax = CW'(RATIO - 1);

  logic [CW-1:0]          r_cnt;
  logic [WIDTH*RATIO-1:0] r_data;
  logic [RATIO-1:0]       r_keep;
  logic                   r_valid;
  logic                   r_last;

  logic [CW-1:0]          w_cnt_d;
  logic [WIDTH*RATIO-1:0] w_data_d;
  logic [RATIO-1:0]       w_keep_d;
  logic                   w_valid_d;
  logic                   w_last_d;
  logic                   w_acc;
  logic                   w_cons;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign data_out  = r_data;
  assign out_keep  = r_keep;
  assign out_last  = r_last;

  assign w_acc  = in_valid && in_ready;
  assign w_cons = r_valid && out_ready;

  always_comb begin
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_keep_d  = r_keep;
    w_valid_d = r_valid;
    w_last_d  = r_last;
    if (w_acc) begin
      // A beat accepted while a word is shown means that word is being consumed now.
      if (r_valid) begin
        w_data_d = '0;
        w_keep_d = '0;
      end
      for (int i = 0; i < int'(RATIO); i++) begin
        if (r_cnt == CW'(i)) begin
          w_data_d[i*WIDTH +: WIDTH] = data_in;
          w_keep_d[i]                = 1'b1;
        end
      end
      if (r_cnt == CntMax || in_last) begin
        w_cnt_d   = '0;
        w_valid_d = 1'b1;
        w_last_d  = in_last;
      end else begin
        w_cnt_d   = r_cnt + 1'b1;
        w_valid_d = 1'b0;
        w_last_d  = 1'b0;
      end
    end else if (w_cons) begin
      w_data_d  = '0;
      w_keep_d  = '0;
      w_valid_d = 1'b0;
      w_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_data  <= w_data_d;
      r_keep  <= w_keep_d;
      r_valid <= w_valid_d;
      r_last  <= w_last_d;
    end
  end

endmodule

// File: tb/tb_ehl_rv_pack.sv
// Directed bench for ehl_rv_pack with WIDTH=8, RATIO=4.
module tb_ehl_rv_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_in;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  out_keep;
  logic        out_last;

  int n_vec = 0;
  int n_err = 0;

  ehl_rv_pack #(.WIDTH(8), .RATIO(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic v, input logic [31:0] d,
                          input logic [3:0] k, input logic l);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".keep"}, {28'd0, out_keep}, {28'd0, k});
    chk({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    data_in  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_word("rst", 1'b0, 32'h0, 4'h0, 1'b0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Full word
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    chk("full.partial_valid", {31'd0, out_valid}, 32'd0);
    beat(8'h44, 1'b0);
    chk_word("full", 1'b1, 32'h44332211, 4'hF, 1'b0);
    idle();
    chk_word("full.clear", 1'b0, 32'h0, 4'h0, 1'b0);

    // Short word closed by in_last
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    chk_word("short", 1'b1, 32'h0000BBAA, 4'h3, 1'b1);
    beat(8'hCC, 1'b0);
    chk_word("short.next", 1'b0, 32'h000000CC, 4'h1, 1'b0);
    beat(8'hDD, 1'b0);
    beat(8'hEE, 1'b0);
    beat(8'hFF, 1'b0);
    chk_word("word2", 1'b1, 32'hFFEEDDCC, 4'hF, 1'b0);

    // Backpressure for 5 cycles with a beat waiting
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'h12;
    #1;
    chk("bp.in_ready0", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      chk_word("bp.hold", 1'b1, 32'hFFEEDDCC, 4'hF, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_word("bp.lane0", 1'b0, 32'h00000012, 4'h1, 1'b0);
    beat(8'h13, 1'b0);
    beat(8'h14, 1'b0);
    beat(8'h15, 1'b0);
    chk_word("bp.word", 1'b1, 32'h15141312, 4'hF, 1'b0);
    idle();
    chk_word("bp.clear", 1'b0, 32'h0, 4'h0, 1'b0);

    // Continuous stream, one word every 4 cycles
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1;
      data_in  = 8'(k);
      #1;
      chk("stream.in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (k % 4 == 0)
        chk_word("stream.word", 1'b1,
                 {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)}, 4'hF, 1'b0);
      else
        chk("stream.gap", {31'd0, out_valid}, 32'd0);
    end
    idle();
    chk_word("stream.clear", 1'b0, 32'h0, 4'h0, 1'b0);

    // Reset mid-word
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    chk("rstmid.partial", data_out, 32'h00006655);
    reset = 1'b1;
    #1;
    chk_word("rstmid.async", 1'b0, 32'h0, 4'h0, 1'b0);
    chk("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    beat(8'h77, 1'b0);
    beat(8'h78, 1'b0);
    beat(8'h79, 1'b0);
    beat(8'h7A, 1'b0);
    chk_word("rstmid.word", 1'b1, 32'h7A797877, 4'hF, 1'b0);
    idle();

    // Single-beat word
    beat(8'hF0, 1'b1);
    chk_word("single", 1'b1, 32'h000000F0, 4'h1, 1'b1);
    idle();

    // in_last on the final lane
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b1);
    chk_word("lastfull", 1'b1, 32'h04030201, 4'hF, 1'b1);
    beat(8'h09, 1'b0);
    chk_word("lastfull.next", 1'b0, 32'h00000009, 4'h1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
